// File: rtl/fft_frame_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_frame_scheduler : ping-pong frame banking and FFT stream/drain sequencing
// Revision 1.0
// ---------------------------------------------------------------------------
module fft_frame_scheduler #(
  parameter int FRAME_LEN = 512,
  parameter int ADDR_W    = 9,
  parameter int OVR_W     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              sample_valid,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_en,
  output logic              rd_bank,
  output logic [ADDR_W-2:0] rd_addr,
  output logic              fft_next,
  input  logic              fft_next_out,
  output logic              out_valid,
  output logic [ADDR_W-2:0] out_index,
  output logic              frame_done,
  output logic              busy,
  output logic [OVR_W-1:0]  overrun
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STREAM   = 2'd1,
    S_WAIT_OUT = 2'd2,
    S_DRAIN    = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-2:0] LAST_PAIR = '1;
  localparam logic [ADDR_W-2:0] PAIR_ONE  = {{(ADDR_W-2){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [ADDR_W-2:0] cnt, cnt_nxt;
  logic [1:0]        full;
  logic              wr_bank_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [OVR_W-1:0]  overrun_q;
  logic              done_q;
  logic              done_set;
  logic              release_set;
  logic              rel_pending;
  logic              rel_bank;
  logic              rd_bank_q;
  logic              do_write;
  logic              do_drop;

  assign do_write = sample_valid && !full[wr_bank_q];
  assign do_drop  = sample_valid &&  full[wr_bank_q];

  // Gated by reset_n so no write strobe escapes while the block is held in reset.
  assign wr_en      = do_write && reset_n;
  assign wr_bank    = wr_bank_q;
  assign wr_addr    = wr_addr_q;
  assign rd_bank    = rd_bank_q;
  assign overrun    = overrun_q;
  assign frame_done = done_q;
  assign busy       = (state != S_IDLE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    fft_next    = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    out_valid   = 1'b0;
    out_index   = '0;
    done_set    = 1'b0;
    release_set = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && full[rd_bank_q]) begin
          fft_next  = 1'b1;
          rd_en     = 1'b1;
          cnt_nxt   = PAIR_ONE;
          state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        rd_en   = 1'b1;
        rd_addr = cnt;
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_PAIR) begin
          release_set = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = S_WAIT_OUT;
        end
      end
      S_WAIT_OUT: begin
        if (fft_next_out) begin
          cnt_nxt   = '0;
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_index = cnt;
        cnt_nxt   = cnt + 1'b1;
        if (cnt == LAST_PAIR) begin
          done_set  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      done_q      <= 1'b0;
      rd_bank_q   <= 1'b0;
      rel_pending <= 1'b0;
      rel_bank    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      done_q      <= done_set;
      rel_pending <= release_set;
      if (release_set) begin
        rel_bank  <= rd_bank_q;
        rd_bank_q <= ~rd_bank_q;
      end
    end
  end

  // The release takes effect one cycle late, so a strobe coinciding with it is still dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full      <= 2'b00;
      wr_bank_q <= 1'b0;
      wr_addr_q <= '0;
      overrun_q <= '0;
    end else begin
      if (do_write) begin
        if (wr_addr_q == LAST_ADDR) begin
          full[wr_bank_q] <= 1'b1;
          wr_addr_q       <= '0;
          wr_bank_q       <= ~wr_bank_q;
        end else begin
          wr_addr_q <= wr_addr_q + 1'b1;
        end
      end
      if (rel_pending) begin
        full[rel_bank] <= 1'b0;
      end
      if (do_drop && (overrun_q != {OVR_W{1'b1}})) begin
        overrun_q <= overrun_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fft_frame_scheduler : directed bench for fft_frame_scheduler (FRAME_LEN=8)
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_fft_frame_scheduler;

  localparam int FL = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic enable;
  logic sample_valid;
  logic fft_next_out;

  logic          wr_en, wr_bank, rd_en, rd_bank, fft_next, out_valid, frame_done, busy;
  logic [AW-1:0] wr_addr;
  logic [AW-2:0] rd_addr, out_index;
  logic [7:0]    overrun;

  logic          s_wr_en, s_wr_bank, s_rd_en, s_rd_bank, s_fft_next, s_out_valid, s_frame_done, s_busy;
  logic [AW-1:0] s_wr_addr;
  logic [AW-2:0] s_rd_addr, s_out_index;
  logic [1:0]    s_overrun;

  int checks   = 0;
  int failures = 0;

  fft_frame_scheduler #(.FRAME_LEN(FL), .ADDR_W(AW), .OVR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sample_valid(sample_valid),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .fft_next(fft_next), .fft_next_out(fft_next_out),
    .out_valid(out_valid), .out_index(out_index), .frame_done(frame_done),
    .busy(busy), .overrun(overrun)
  );

  // Narrow overrun counter instance driven by the same stimulus.
  fft_frame_scheduler #(.FRAME_LEN(FL), .ADDR_W(AW), .OVR_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sample_valid(sample_valid),
    .wr_en(s_wr_en), .wr_bank(s_wr_bank), .wr_addr(s_wr_addr),
    .rd_en(s_rd_en), .rd_bank(s_rd_bank), .rd_addr(s_rd_addr),
    .fft_next(s_fft_next), .fft_next_out(fft_next_out),
    .out_valid(s_out_valid), .out_index(s_out_index), .frame_done(s_frame_done),
    .busy(s_busy), .overrun(s_overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic exp_en, input int bank, input int addr);
    sample_valid = 1'b1;
    #1;
    check_eq("wr_en", 32'(wr_en), 32'(exp_en));
    if (exp_en) begin
      check_eq("wr_bank", 32'(wr_bank), bank);
      check_eq("wr_addr", 32'(wr_addr), addr);
    end
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; fft_next_out = 1'b0;
    #12;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_rd_en", 32'(rd_en), 0);
    check_eq("rst_wr_bank", 32'(wr_bank), 0);
    check_eq("rst_overrun", 32'(overrun), 0);
    tick();
    reset_n = 1'b1;
    enable  = 1'b1;

    // Fill bank 0 with spaced strobes, then the stream starts on the next cycle.
    for (int i = 0; i < FL; i++) begin
      if (i > 0) repeat (3) tick();
      send(1'b1, 0, i);
    end
    check_eq("start_fft_next", 32'(fft_next), 1);
    check_eq("start_rd_en", 32'(rd_en), 1);
    check_eq("start_rd_addr", 32'(rd_addr), 0);
    check_eq("start_rd_bank", 32'(rd_bank), 0);
    check_eq("start_wr_bank", 32'(wr_bank), 1);
    check_eq("start_busy", 32'(busy), 0);
    for (int k = 1; k < FL/2; k++) begin
      tick();
      check_eq("stream_rd_addr", 32'(rd_addr), k);
      check_eq("stream_rd_en", 32'(rd_en), 1);
      check_eq("stream_fft_next", 32'(fft_next), 0);
      check_eq("stream_busy", 32'(busy), 1);
    end
    tick();
    check_eq("wait_rd_en", 32'(rd_en), 0);
    check_eq("wait_rd_bank", 32'(rd_bank), 1);
    check_eq("wait_busy", 32'(busy), 1);

    // FFT output burst ten cycles after the stream ends.
    repeat (9) tick();
    fft_next_out = 1'b1;
    #1;
    check_eq("pulse_out_valid", 32'(out_valid), 0);
    tick();
    fft_next_out = 1'b0;
    for (int k = 0; k < FL/2; k++) begin
      check_eq("drain_out_valid", 32'(out_valid), 1);
      check_eq("drain_out_index", 32'(out_index), k);
      check_eq("drain_frame_done", 32'(frame_done), 0);
      tick();
    end
    check_eq("done_pulse", 32'(frame_done), 1);
    check_eq("done_busy", 32'(busy), 0);
    check_eq("done_out_valid", 32'(out_valid), 0);
    tick();
    check_eq("done_clear", 32'(frame_done), 0);

    // Both banks full with the scheduler held off, then overrun drops.
    enable = 1'b0;
    for (int i = 0; i < FL; i++) send(1'b1, 1, i);
    for (int i = 0; i < FL; i++) send(1'b1, 0, i);
    check_eq("hold_fft_next", 32'(fft_next), 0);
    check_eq("hold_busy", 32'(busy), 0);
    for (int i = 0; i < 3; i++) send(1'b0, 0, 0);
    check_eq("ovr_3", 32'(overrun), 3);
    check_eq("ovr_wr_addr", 32'(wr_addr), 0);
    check_eq("ovr_wr_bank", 32'(wr_bank), 1);
    for (int i = 0; i < 3; i++) send(1'b0, 0, 0);
    check_eq("ovr_6", 32'(overrun), 6);
    check_eq("ovr_sat", 32'(s_overrun), 3);

    // Raising enable starts the bank-1 stream; fft_next_out during STREAM is ignored.
    enable = 1'b1;
    #1;
    check_eq("en_fft_next", 32'(fft_next), 1);
    check_eq("en_rd_bank", 32'(rd_bank), 1);
    tick();
    fft_next_out = 1'b1;
    check_eq("s2_rd_addr1", 32'(rd_addr), 1);
    tick();
    fft_next_out = 1'b0;
    check_eq("s2_rd_addr2", 32'(rd_addr), 2);
    tick();
    check_eq("s2_rd_addr3", 32'(rd_addr), 3);
    tick();
    check_eq("s2_rd_en", 32'(rd_en), 0);
    check_eq("s2_rd_bank", 32'(rd_bank), 0);
    send(1'b0, 0, 0);
    check_eq("release_drop", 32'(overrun), 7);
    send(1'b1, 1, 0);
    check_eq("after_release_ovr", 32'(overrun), 7);
    check_eq("ignored_pulse", 32'(out_valid), 0);

    // Dropping enable during DRAIN still completes the frame.
    fft_next_out = 1'b1;
    tick();
    fft_next_out = 1'b0;
    enable = 1'b0;
    for (int k = 0; k < FL/2; k++) begin
      check_eq("d2_out_index", 32'(out_index), k);
      check_eq("d2_out_valid", 32'(out_valid), 1);
      tick();
    end
    check_eq("d2_frame_done", 32'(frame_done), 1);
    tick();
    check_eq("d2_no_start", 32'(fft_next), 0);
    check_eq("d2_idle", 32'(busy), 0);

    // Reset in the middle of a stream.
    enable = 1'b1;
    #1;
    check_eq("r_fft_next", 32'(fft_next), 1);
    check_eq("r_rd_bank", 32'(rd_bank), 0);
    tick();
    tick();
    check_eq("r_rd_addr2", 32'(rd_addr), 2);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_rd_en", 32'(rd_en), 0);
    check_eq("mid_rst_rd_addr", 32'(rd_addr), 0);
    check_eq("mid_rst_busy", 32'(busy), 0);
    check_eq("mid_rst_overrun", 32'(overrun), 0);
    check_eq("mid_rst_wr_addr", 32'(wr_addr), 0);
    check_eq("mid_rst_wr_bank", 32'(wr_bank), 0);
    check_eq("mid_rst_fft_next", 32'(fft_next), 0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < FL; i++) send(1'b1, 0, i);
    check_eq("fresh_fft_next", 32'(fft_next), 1);
    check_eq("fresh_rd_bank", 32'(rd_bank), 0);
    check_eq("fresh_rd_addr", 32'(rd_addr), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
